cla_adder: RTL and testbench

- Parameterised N-bit carry-lookahead adder, one of three interchangeable 64-bit adder implementations in the adder family, alongside the ripple-carry and prefix adders.
- Computes Sum/Cout combinationally from A, B and Cin.
- Also provides a registered copy of the result for pipelined integration.
- Used as the arithmetic core wherever a fast N-bit add with carry-in/carry-out is required.

---
 rtl/adder_pkg.sv | 22 ++
 rtl/cla_block4.sv | 27 ++
 rtl/cla_adder.sv | 68 ++++++
 tb/tb_cla_adder.sv | 137 +++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the adder family: block width, default operand width
// and the 4-bit lookahead carry equations.
package adder_pkg;

  localparam int unsigned CLA_BLOCK       = 4;
  localparam int unsigned ADDER_W_DEFAULT = 64;

  // Returns the carries into bits 0..3 of a 4-bit group, all two levels deep
  function automatic logic [3:0] cla4_carries(
    input logic [3:0] g,
    input logic [3:0] p,
    input logic       c0
  );
    logic [3:0] c;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    return c;
  endfunction

endpackage

// File: rtl/cla_block4.sv
// 4-bit carry-lookahead block: local sum from its block carry-in, plus group
// generate/propagate for the inter-block carry chain.
module cla_block4
  import adder_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       G,
  output logic       P
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  always_comb begin
    g   = a & b;
    p   = a ^ b;
    c   = cla4_carries(g, p, cin);
    sum = p ^ c;
    G   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    P   = &p;
  end

endmodule

// File: rtl/cla_adder.sv
// N-bit carry-lookahead adder built from 4-bit blocks, with a combinational
// result and a one-cycle registered copy.
module cla_adder
  import adder_pkg::*;
#(
  parameter int unsigned N = ADDER_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] Sum,
  output logic         Cout,
  output logic [N-1:0] Sum_q,
  output logic         Cout_q
);

  localparam int unsigned NB = N / CLA_BLOCK;

  logic [NB:0]   c_blk;
  logic [NB-1:0] blk_g;
  logic [NB-1:0] blk_p;

  for (genvar k = 0; k < NB; k++) begin : g_blk
    cla_block4 u_blk (
      .a   (A[k*CLA_BLOCK +: CLA_BLOCK]),
      .b   (B[k*CLA_BLOCK +: CLA_BLOCK]),
      .cin (c_blk[k]),
      .sum (Sum[k*CLA_BLOCK +: CLA_BLOCK]),
      .G   (blk_g[k]),
      .P   (blk_p[k])
    );
  end

  // Chain kept in one process so the self-referencing vector evaluates in order
  always_comb begin
    c_blk    = '0;
    c_blk[0] = Cin;
    for (int unsigned k = 0; k < NB; k++) begin
      c_blk[k+1] = blk_g[k] | (blk_p[k] & c_blk[k]);
    end
  end

  assign Cout = c_blk[NB];

  logic [N-1:0] sum_d, sum_q;
  logic         cout_d, cout_q;

  always_comb begin
    sum_d  = Sum;
    cout_d = Cout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign Sum_q  = sum_q;
  assign Cout_q = cout_q;

endmodule

// File: tb/tb_cla_adder.sv
// Scoreboard bench for cla_adder: expected results are queued at stimulus time
// and popped by independent combinational and registered monitors.
module tb_cla_adder;

  localparam int unsigned W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] A, B;
  logic         Cin;
  logic [W-1:0] Sum, Sum_q;
  logic         Cout, Cout_q;

  int checks   = 0;
  int failures = 0;

  logic [W:0] comb_q[$];
  logic [W:0] reg_q[$];
  event       issued;

  cla_adder #(.N(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .A      (A),
    .B      (B),
    .Cin    (Cin),
    .Sum    (Sum),
    .Cout   (Cout),
    .Sum_q  (Sum_q),
    .Cout_q (Cout_q)
  );

  always #5 clk = ~clk;

  // Reference: plain 65-bit arithmetic
  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input logic r);
    logic [W:0] e;
    A   = a;
    B   = b;
    Cin = c;
    rst = r;
    e   = ref_add(a, b, c);
    comb_q.push_back(e);
    reg_q.push_back(r ? '0 : e);
    -> issued;
    @(negedge clk);
  endtask

  initial begin : comb_mon
    logic [W:0] e;
    forever begin
      @(issued);
      #1;
      checks++;
      if (comb_q.size() == 0) begin
        failures++;
        $display("FAIL comb_underflow: no expected value queued");
      end else begin
        e = comb_q.pop_front();
        if ({Cout, Sum} !== e) begin
          failures++;
          $display("FAIL comb A=%h B=%h Cin=%b: got Cout=%b Sum=%h, want Cout=%b Sum=%h",
                   A, B, Cin, Cout, Sum, e[W], e[W-1:0]);
        end
      end
    end
  end

  initial begin : reg_mon
    logic [W:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (reg_q.size() != 0) begin
        e = reg_q.pop_front();
        checks++;
        if ({Cout_q, Sum_q} !== e) begin
          failures++;
          $display("FAIL reg: got Cout_q=%b Sum_q=%h, want Cout_q=%b Sum_q=%h",
                   Cout_q, Sum_q, e[W], e[W-1:0]);
        end
      end
    end
  end

  initial begin : timeout
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [W-1:0] a, b;
    logic         c, r;
    A = '0; B = '0; Cin = 1'b0; rst = 1'b1;
    #1;
    drive('0, '0, 1'b0, 1'b1);
    drive('0, '0, 1'b0, 1'b0);
    drive('1, '0, 1'b1, 1'b0);
    drive('1, '1, 1'b1, 1'b0);
    drive(64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 1'b0, 1'b0);
    drive(64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 1'b1, 1'b0);
    drive(64'h8000000000000000, 64'h8000000000000000, 1'b0, 1'b0);
    drive(64'h00000000FFFFFFFF, 64'h1, 1'b0, 1'b0);
    drive('0, '0, 1'b1, 1'b0);
    drive(64'h5, 64'h7, 1'b1, 1'b0);
    drive(64'h5, 64'h7, 1'b1, 1'b1);
    drive(64'h5, 64'h7, 1'b1, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      a = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       b = ~a;
        1:       b = {$urandom, $urandom} & {W{1'b1}} >> $urandom_range(0, 63);
        default: b = {$urandom, $urandom};
      endcase
      c = 1'($urandom);
      r = ($urandom_range(0, 15) == 0);
      drive(a, b, c, r);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (comb_q.size() != 0 || reg_q.size() != 0) begin
      failures++;
      $display("FAIL drain: comb_left=%0d reg_left=%0d, want 0 and 0",
               comb_q.size(), reg_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
